// File: rtl/sw_input_pkg.sv
// Shared types and constants for the switch debounce/sampling front end.
package sw_input_pkg;

    typedef enum logic [0:0] {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    localparam int STABLE_CYCLES_DEFAULT = 1000;
    localparam int SIM_STABLE_CYCLES     = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for asynchronous level inputs; latency 2 cycles, no backpressure.
// Both stages clear to 0 on synchronous active-high reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/sw_debounce_sampler.sv
// Debounces {raw_en, raw_data} as one vector; commit STABLE_CYCLES+2 cycles after a clean step, no backpressure.
// Optional change counter output built when SW_DEBOUNCE_STATS_EN is defined.
module sw_debounce_sampler
    import sw_input_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_data,
    input  logic             raw_en,
    output logic [WIDTH-1:0] data_out,
    output logic             en_out,
    output logic             change_pulse,
`ifdef SW_DEBOUNCE_STATS_EN
    output logic             busy,
    output logic [7:0]       change_count
`else
    output logic             busy
`endif
);

    localparam int VW    = WIDTH + 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [VW-1:0]    sync_vec;
    logic [VW-1:0]    cand_q, cand_d;
    logic [VW-1:0]    comm_q, comm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    state_t           state_q, state_d;

    sync_2ff #(
        .WIDTH(VW)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  ({raw_en, raw_data}),
        .q  (sync_vec)
    );

    always_comb begin
        cand_d  = cand_q;
        comm_d  = comm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        pulse_d = 1'b0;
        case (state_q)
            STABLE: begin
                if (sync_vec != comm_q) begin
                    cand_d  = sync_vec;
                    cnt_d   = '0;
                    state_d = SETTLING;
                end
            end
            SETTLING: begin
                // Any bounce restarts the whole window on the new vector.
                if (sync_vec != cand_q) begin
                    cand_d = sync_vec;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE;
                    if (cand_q != comm_q) begin
                        comm_d  = cand_q;
                        pulse_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = STABLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q  <= '0;
            comm_q  <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            state_q <= STABLE;
        end else begin
            cand_q  <= cand_d;
            comm_q  <= comm_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            state_q <= state_d;
        end
    end

`ifdef SW_DEBOUNCE_STATS_EN
    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else if (pulse_d) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign change_count = count_q;
`endif

    assign data_out     = comm_q[WIDTH-1:0];
    assign en_out       = comm_q[WIDTH];
    assign change_pulse = pulse_q;
    assign busy         = (state_q == SETTLING);

endmodule

// File: tb/tb_sw_debounce_sampler.sv
// Directed bench for sw_debounce_sampler at SIM_STABLE_CYCLES: vector table plus corner-case sequences.
module tb_sw_debounce_sampler;
    import sw_input_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw_data;
    logic       raw_en;
    logic [7:0] data_out;
    logic       en_out;
    logic       change_pulse;
    logic       busy;
`ifdef SW_DEBOUNCE_STATS_EN
    logic [7:0] change_count;
`endif

    int checks   = 0;
    int failures = 0;
    int npulse   = 0;

    always #5 clk = ~clk;

    sw_debounce_sampler #(
        .WIDTH        (8),
        .STABLE_CYCLES(SIM_STABLE_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_data    (raw_data),
        .raw_en      (raw_en),
        .data_out    (data_out),
        .en_out      (en_out),
        .change_pulse(change_pulse),
`ifdef SW_DEBOUNCE_STATS_EN
        .busy        (busy),
        .change_count(change_count)
`else
        .busy        (busy)
`endif
    );

    typedef struct {
        logic       rst;
        logic [7:0] raw_d;
        logic       raw_e;
        logic [7:0] exp_d;
        logic       exp_e;
        logic       exp_busy;
        logic       exp_pulse;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic e,
                           input logic b, input logic p);
        chk({tag, ".data"},  {24'd0, data_out}, {24'd0, d});
        chk({tag, ".en"},    {31'd0, en_out},   {31'd0, e});
        chk({tag, ".busy"},  {31'd0, busy},     {31'd0, b});
        chk({tag, ".pulse"}, {31'd0, change_pulse}, {31'd0, p});
    endtask

    // Advance one edge and sample 1 time unit later; tally strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        if (change_pulse === 1'b1) npulse++;
    endtask

`ifdef SW_DEBOUNCE_STATS_EN
    task automatic commit_val(input logic [7:0] v);
        raw_data = v;
        raw_en   = 1'b1;
        repeat (10) tick();
    endtask
`endif

    initial begin
        int  p0;
        logic busy_seen;
        logic data_moved;
        logic [7:0] bounce_vals [5];

        rst      = 1'b1;
        raw_data = 8'hFF;
        raw_en   = 1'b1;

        // Reset then a clean step 0x00/0 -> 0x80/1 applied before row 4 (edge E0).
        tbl[0]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h80, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h80, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h80, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'h80, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 8'h80, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'h80, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h80, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'h80, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'h80, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            rst      = tbl[i].rst;
            raw_data = tbl[i].raw_d;
            raw_en   = tbl[i].raw_e;
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].exp_d, tbl[i].exp_e,
                    tbl[i].exp_busy, tbl[i].exp_pulse);
        end

        // Glitch: 0x01 for two samples then back to the committed 0x80.
        p0         = npulse;
        busy_seen  = 1'b0;
        data_moved = 1'b0;
        raw_data   = 8'h01;
        tick();
        tick();
        raw_data = 8'h80;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (busy === 1'b1) busy_seen = 1'b1;
            if (data_out !== 8'h80) data_moved = 1'b1;
        end
        chk("glitch.pulses", npulse - p0, 0);
        chk("glitch.busy_seen", {31'd0, busy_seen}, 1);
        chk("glitch.data_moved", {31'd0, data_moved}, 0);
        chk_out("glitch.end", 8'h80, 1'b1, 1'b0, 1'b0);

        // Bounce on bit 3, then hold 0x08 from edge E.
        p0 = npulse;
        bounce_vals = '{8'h00, 8'h08, 8'h00, 8'h08, 8'h00};
        for (int k = 0; k < 5; k++) begin
            raw_data = bounce_vals[k];
            tick();
        end
        raw_data = 8'h08;
        tick();
        repeat (5) tick();
        chk_out("bounce.e5", 8'h80, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("bounce.e6", 8'h08, 1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        chk("bounce.pulses", npulse - p0, 1);
        chk_out("bounce.end", 8'h08, 1'b1, 1'b0, 1'b0);

        // Reset while settling on 0x40.
        p0       = npulse;
        raw_data = 8'h40;
        tick();
        tick();
        tick();
        chk("midrst.busy_s2", {31'd0, busy}, 1);
        tick();
        chk("midrst.busy_s3", {31'd0, busy}, 1);
        rst = 1'b1;
        tick();
        chk_out("midrst.rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        repeat (5) tick();
        chk_out("midrst.r5", 8'h00, 1'b0, 1'b1, 1'b0);
        chk("midrst.no_pulse", npulse - p0, 0);
        tick();
        chk_out("midrst.r6", 8'h40, 1'b1, 1'b0, 1'b1);

`ifdef SW_DEBOUNCE_STATS_EN
        rst      = 1'b1;
        raw_data = 8'h00;
        raw_en   = 1'b0;
        tick();
        rst = 1'b0;
        chk("stats.reset", {24'd0, change_count}, 0);
        commit_val(8'h11);
        commit_val(8'h22);
        commit_val(8'h33);
        raw_data = 8'h55;
        tick();
        tick();
        raw_data = 8'h33;
        repeat (12) tick();
        chk("stats.three", {24'd0, change_count}, 3);

        rst = 1'b1;
        tick();
        rst      = 1'b0;
        raw_data = 8'h00;
        raw_en   = 1'b0;
        for (int n = 0; n < 256; n++) begin
            commit_val((n % 2 == 0) ? 8'h5A : 8'hA5);
            if (n == 254) chk("stats.255", {24'd0, change_count}, 255);
        end
        chk("stats.wrap", {24'd0, change_count}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
